// File: rtl/dcache_pkg.sv
// Shared types, geometry constants and address helpers for the data cache.
// Geometry: 8-bit byte address, 8 lines of 4 bytes, direct mapped.
package dcache_pkg;

    localparam int ADDR_W     = 8;
    localparam int NUM_LINES  = 8;
    localparam int LINE_BYTES = 4;
    localparam int IDX_W      = $clog2(NUM_LINES);
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int TAG_W      = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W     = 8 * LINE_BYTES;
    localparam int MADDR_W    = ADDR_W - OFF_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return a[OFF_W +: IDX_W];
    endfunction

    function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
        return a[OFF_W-1:0];
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Tag/valid/dirty/data storage for the direct-mapped cache.
// Combinational read port, clocked byte-write and line-fill ports.
module dcache_line_array
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  idx,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [LINE_W-1:0] rd_line,
    input  logic              wr_en,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic [7:0]        wr_byte,
    input  logic              fill_en,
    input  logic [IDX_W-1:0]  fill_idx,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [LINE_W-1:0] fill_line
);

    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;

    assign rd_tag   = tag_q[idx];
    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_line  = data_q[idx];

    // Line state: fill makes a line valid and clean, a byte store dirties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
            dirty_q[fill_idx] <= 1'b0;
        end else if (wr_en) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tag and data storage; left uninitialised, validity lives in valid_q.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= fill_line;
        end else if (wr_en) begin
            data_q[idx][{wr_off, 3'b000} +: 8] <= wr_byte;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache controller with busy-wait memory side.
// Define DCACHE_STATS_EN to add saturating HIT_COUNT/MISS_COUNT outputs.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               READ,
    input  logic               WRITE,
    input  logic [ADDR_W-1:0]  ADDRESS,
    input  logic [7:0]         WRITEDATA,
    output logic [7:0]         READDATA,
    output logic               BUSYWAIT,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic [MADDR_W-1:0] MEM_ADDRESS,
    output logic [LINE_W-1:0]  MEM_WRITEDATA,
    input  logic [LINE_W-1:0]  MEM_READDATA,
    input  logic               MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]        HIT_COUNT,
    output logic [15:0]        MISS_COUNT
`endif
);

    state_t             state;
    logic [TAG_W-1:0]   tag;
    logic [IDX_W-1:0]   idx;
    logic [OFF_W-1:0]   off;
    logic [TAG_W-1:0]   rd_tag;
    logic               rd_valid;
    logic               rd_dirty;
    logic [LINE_W-1:0]  rd_line;
    logic               hit;
    logic               req;
    logic               miss;
    logic               wr_en;
    logic               fill_en;
    logic [TAG_W-1:0]   miss_tag;
    logic [IDX_W-1:0]   miss_idx;
    logic [LINE_W-1:0]  fill_buf;

    assign tag  = addr_tag(ADDRESS);
    assign idx  = addr_idx(ADDRESS);
    assign off  = addr_off(ADDRESS);
    assign hit  = rd_valid & (rd_tag == tag);
    assign req  = READ | WRITE;
    assign miss = (state == IDLE) & req & ~hit;

    assign BUSYWAIT = RESET_N & ((state != IDLE) | (req & ~hit));
    assign READDATA = hit ? rd_line[{off, 3'b000} +: 8] : 8'h00;
    assign wr_en    = (state == IDLE) & WRITE & hit;
    assign fill_en  = (state == UPDATE);

    dcache_line_array u_lines (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .idx       (idx),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_line   (rd_line),
        .wr_en     (wr_en),
        .wr_off    (off),
        .wr_byte   (WRITEDATA),
        .fill_en   (fill_en),
        .fill_idx  (miss_idx),
        .fill_tag  (miss_tag),
        .fill_line (fill_buf)
    );

    // Miss sequencer; the missing line is latched so a withdrawn request still fills.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= IDLE;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= '0;
            miss_tag      <= '0;
            miss_idx      <= '0;
            fill_buf      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (miss) begin
                        miss_tag <= tag;
                        miss_idx <= idx;
                        if (rd_valid & rd_dirty) begin
                            state         <= WRITEBACK;
                            MEM_WRITE     <= 1'b1;
                            MEM_ADDRESS   <= {rd_tag, idx};
                            MEM_WRITEDATA <= rd_line;
                        end else begin
                            state       <= REFILL;
                            MEM_READ    <= 1'b1;
                            MEM_ADDRESS <= {tag, idx};
                        end
                    end
                end
                WRITEBACK: begin
                    if (!MEM_BUSYWAIT) begin
                        state       <= REFILL;
                        MEM_WRITE   <= 1'b0;
                        MEM_READ    <= 1'b1;
                        MEM_ADDRESS <= {miss_tag, miss_idx};
                    end
                end
                REFILL: begin
                    if (!MEM_BUSYWAIT) begin
                        state    <= UPDATE;
                        MEM_READ <= 1'b0;
                        fill_buf <= MEM_READDATA;
                    end
                end
                UPDATE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic post_fill;

    // Saturating hit/miss counters; the hit right after a fill is not a new hit.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            HIT_COUNT  <= 16'h0000;
            MISS_COUNT <= 16'h0000;
            post_fill  <= 1'b0;
        end else begin
            post_fill <= (state == UPDATE);
            if ((state == IDLE) & req & hit & ~post_fill & (HIT_COUNT != 16'hFFFF))
                HIT_COUNT <= HIT_COUNT + 16'd1;
            if (miss & (MISS_COUNT != 16'hFFFF))
                MISS_COUNT <= MISS_COUNT + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a fixed-latency line memory.
// Build with DCACHE_STATS_EN to also exercise the hit/miss counters.
module tb_dcache_controller;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;
`ifdef DCACHE_STATS_EN
    logic [15:0] HIT_COUNT;
    logic [15:0] MISS_COUNT;
`endif

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [64];
    logic        mem_init;
    int          lat;
    int          mcnt;

    always #5 CLK = ~CLK;

    dcache_controller dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
        ,
        .HIT_COUNT     (HIT_COUNT),
        .MISS_COUNT    (MISS_COUNT)
`endif
    );

    // Memory: transfer completes on the lat-th cycle of a request.
    assign MEM_BUSYWAIT = !((MEM_READ || MEM_WRITE) && (mcnt == lat - 1));
    assign MEM_READDATA = MEM_READ ? mem[MEM_ADDRESS] : 32'h0;

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) mcnt <= 0;
        else if (MEM_READ || MEM_WRITE) mcnt <= (mcnt == lat - 1) ? 0 : mcnt + 1;
        else mcnt <= 0;
    end

    always @(posedge CLK) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= {4{i[7:0]}};
            mem[5]  <= 32'hDDCCBBAA;
            mem[13] <= 32'h11223344;
            mem[11] <= 32'hCAFEBABE;
            mem[18] <= 32'h01020304;
        end else if (MEM_WRITE && (mcnt == lat - 1)) begin
            mem[MEM_ADDRESS] <= MEM_WRITEDATA;
        end
    end

    task automatic cpu(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        @(negedge CLK);
        READ = r;
        WRITE = w;
        ADDRESS = a;
        WRITEDATA = d;
        #1;
    endtask

    task automatic wait_ready(output int stall, output int rdc, output int wrc,
                              output bit ov, output logic [5:0] waddr,
                              output logic [5:0] raddr, output logic [31:0] wdata);
        stall = 0; rdc = 0; wrc = 0; ov = 0;
        waddr = '0; raddr = '0; wdata = '0;
        while (BUSYWAIT && stall < 300) begin
            @(negedge CLK);
            #1;
            stall++;
            if (MEM_READ) begin rdc++; raddr = MEM_ADDRESS; end
            if (MEM_WRITE) begin wrc++; waddr = MEM_ADDRESS; wdata = MEM_WRITEDATA; end
            if (MEM_READ && MEM_WRITE) ov = 1;
        end
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; READ = 1'b1; WRITE = 1'b0;
        ADDRESS = 8'h14; WRITEDATA = 8'h00;
        mem_init = 1'b1; lat = 5;
        repeat (2) @(negedge CLK);
        mem_init = 1'b0;
        #1;
        checks++; if (BUSYWAIT !== 1'b0) begin failures++; $display("FAIL reset_busywait got=%b exp=0", BUSYWAIT); end
        checks++; if (READDATA !== 8'h00) begin failures++; $display("FAIL reset_readdata got=%h exp=00", READDATA); end
        checks++; if ({MEM_READ, MEM_WRITE} !== 2'b00) begin failures++; $display("FAIL reset_memreq got=%b exp=00", {MEM_READ, MEM_WRITE}); end
        checks++; if (MEM_ADDRESS !== 6'h00 || MEM_WRITEDATA !== 32'h0) begin failures++; $display("FAIL reset_memaddr got=%h/%h exp=00/0", MEM_ADDRESS, MEM_WRITEDATA); end
        @(negedge CLK);
        READ = 1'b0;
        RESET_N = 1'b1;
    endtask

    task automatic test_read_miss();
        int st, rc, wc; bit ov; logic [5:0] wa, ra; logic [31:0] wd;
        lat = 5;
        cpu(1, 0, 8'h14, 8'h00);
        checks++; if (BUSYWAIT !== 1'b1) begin failures++; $display("FAIL rmiss_busy got=%b exp=1", BUSYWAIT); end
        checks++; if (MEM_READ !== 1'b0) begin failures++; $display("FAIL rmiss_memread_reg got=%b exp=0", MEM_READ); end
        wait_ready(st, rc, wc, ov, wa, ra, wd);
        checks++; if (st != 7) begin failures++; $display("FAIL rmiss_stall got=%0d exp=7", st); end
        checks++; if (rc != 5 || ra !== 6'h05) begin failures++; $display("FAIL rmiss_memread got=%0d@%h exp=5@05", rc, ra); end
        checks++; if (wc != 0) begin failures++; $display("FAIL rmiss_nowrite got=%0d exp=0", wc); end
        checks++; if (READDATA !== 8'hAA) begin failures++; $display("FAIL rmiss_data got=%h exp=AA", READDATA); end
    endtask

    task automatic test_write_hit();
        cpu(0, 1, 8'h15, 8'h5A);
        checks++; if (BUSYWAIT !== 1'b0) begin failures++; $display("FAIL whit_busy got=%b exp=0", BUSYWAIT); end
        checks++; if ({MEM_READ, MEM_WRITE} !== 2'b00) begin failures++; $display("FAIL whit_memreq got=%b exp=00", {MEM_READ, MEM_WRITE}); end
        cpu(1, 0, 8'h15, 8'h00);
        checks++; if (READDATA !== 8'h5A || BUSYWAIT !== 1'b0) begin failures++; $display("FAIL whit_readback got=%h/%b exp=5A/0", READDATA, BUSYWAIT); end
    endtask

    task automatic test_dirty_miss();
        int st, rc, wc; bit ov; logic [5:0] wa, ra; logic [31:0] wd;
        lat = 5;
        cpu(1, 0, 8'h34, 8'h00);
        checks++; if (BUSYWAIT !== 1'b1) begin failures++; $display("FAIL dmiss_busy got=%b exp=1", BUSYWAIT); end
        wait_ready(st, rc, wc, ov, wa, ra, wd);
        checks++; if (st != 12) begin failures++; $display("FAIL dmiss_stall got=%0d exp=12", st); end
        checks++; if (wc != 5 || wa !== 6'h05) begin failures++; $display("FAIL dmiss_wb got=%0d@%h exp=5@05", wc, wa); end
        checks++; if (wd !== 32'hDDCC5AAA) begin failures++; $display("FAIL dmiss_wbdata got=%h exp=DDCC5AAA", wd); end
        checks++; if (rc != 5 || ra !== 6'h0D) begin failures++; $display("FAIL dmiss_refill got=%0d@%h exp=5@0D", rc, ra); end
        checks++; if (ov != 0) begin failures++; $display("FAIL dmiss_overlap got=%0d exp=0", ov); end
        checks++; if (READDATA !== 8'h44) begin failures++; $display("FAIL dmiss_data got=%h exp=44", READDATA); end
        checks++; if (mem[5] !== 32'hDDCC5AAA) begin failures++; $display("FAIL dmiss_memline got=%h exp=DDCC5AAA", mem[5]); end
    endtask

    task automatic test_reset_mid();
        int st, rc, wc; bit ov; logic [5:0] wa, ra; logic [31:0] wd;
        lat = 5;
        cpu(1, 0, 8'h14, 8'h00);
        @(negedge CLK);
        #1;
        checks++; if (MEM_READ !== 1'b1) begin failures++; $display("FAIL rmid_inrefill got=%b exp=1", MEM_READ); end
        RESET_N = 1'b0;
        #1;
        checks++; if (MEM_READ !== 1'b0 || BUSYWAIT !== 1'b0) begin failures++; $display("FAIL rmid_drop got=%b/%b exp=0/0", MEM_READ, BUSYWAIT); end
        @(negedge CLK);
        RESET_N = 1'b1;
        #1;
        checks++; if (BUSYWAIT !== 1'b1) begin failures++; $display("FAIL rmid_missagain got=%b exp=1", BUSYWAIT); end
        wait_ready(st, rc, wc, ov, wa, ra, wd);
        checks++; if (st != 7 || READDATA !== 8'hAA) begin failures++; $display("FAIL rmid_refetch got=%0d/%h exp=7/AA", st, READDATA); end
    endtask

    task automatic test_withdraw();
        int st, rc, wc; bit ov; logic [5:0] wa, ra; logic [31:0] wd;
        lat = 5;
        cpu(1, 0, 8'h2C, 8'h00);
        @(negedge CLK);
        READ = 1'b0;
        #1;
        checks++; if (BUSYWAIT !== 1'b1 || MEM_READ !== 1'b1) begin failures++; $display("FAIL wdraw_hold got=%b/%b exp=1/1", BUSYWAIT, MEM_READ); end
        wait_ready(st, rc, wc, ov, wa, ra, wd);
        checks++; if (st != 6 || rc != 4) begin failures++; $display("FAIL wdraw_finish got=%0d/%0d exp=6/4", st, rc); end
        cpu(1, 0, 8'h2D, 8'h00);
        checks++; if (BUSYWAIT !== 1'b0 || READDATA !== 8'hBA) begin failures++; $display("FAIL wdraw_hit got=%b/%h exp=0/BA", BUSYWAIT, READDATA); end
    endtask

    task automatic test_fast_mem();
        int st, rc, wc; bit ov; logic [5:0] wa, ra; logic [31:0] wd;
        lat = 1;
        cpu(1, 0, 8'h44, 8'h00);
        wait_ready(st, rc, wc, ov, wa, ra, wd);
        checks++; if (st != 3 || rc != 1 || ra !== 6'h11) begin failures++; $display("FAIL fast_refill got=%0d/%0d@%h exp=3/1@11", st, rc, ra); end
        checks++; if (READDATA !== 8'h11) begin failures++; $display("FAIL fast_data got=%h exp=11", READDATA); end
    endtask

    task automatic test_write_miss();
        int st, rc, wc; bit ov; logic [5:0] wa, ra; logic [31:0] wd;
        lat = 2;
        cpu(0, 1, 8'h48, 8'h77);
        wait_ready(st, rc, wc, ov, wa, ra, wd);
        checks++; if (st != 4 || wc != 0) begin failures++; $display("FAIL wmiss_stall got=%0d/%0d exp=4/0", st, wc); end
        cpu(1, 0, 8'h48, 8'h00);
        checks++; if (READDATA !== 8'h77) begin failures++; $display("FAIL wmiss_byte got=%h exp=77", READDATA); end
        cpu(1, 0, 8'h49, 8'h00);
        checks++; if (READDATA !== 8'h03) begin failures++; $display("FAIL wmiss_neighbour got=%h exp=03", READDATA); end
        cpu(1, 1, 8'h49, 8'h99);
        checks++; if (BUSYWAIT !== 1'b0) begin failures++; $display("FAIL rw_busy got=%b exp=0", BUSYWAIT); end
        cpu(1, 0, 8'h49, 8'h00);
        checks++; if (READDATA !== 8'h99) begin failures++; $display("FAIL rw_asstore got=%h exp=99", READDATA); end
        cpu(0, 0, 8'h00, 8'h00);
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats();
        int st, rc, wc; bit ov; logic [5:0] wa, ra; logic [31:0] wd;
        @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        checks++; if (HIT_COUNT !== 16'h0 || MISS_COUNT !== 16'h0) begin failures++; $display("FAIL stats_reset got=%h/%h exp=0/0", HIT_COUNT, MISS_COUNT); end
        @(negedge CLK);
        RESET_N = 1'b1;
        lat = 5;
        cpu(1, 0, 8'h14, 8'h00);
        wait_ready(st, rc, wc, ov, wa, ra, wd);
        cpu(1, 0, 8'h15, 8'h00);
        cpu(1, 0, 8'h16, 8'h00);
        cpu(1, 0, 8'h34, 8'h00);
        wait_ready(st, rc, wc, ov, wa, ra, wd);
        checks++; if (HIT_COUNT !== 16'd2 || MISS_COUNT !== 16'd2) begin failures++; $display("FAIL stats_count got=%0d/%0d exp=2/2", HIT_COUNT, MISS_COUNT); end
        repeat (65540) @(negedge CLK);
        #1;
        checks++; if (HIT_COUNT !== 16'hFFFF) begin failures++; $display("FAIL stats_sat got=%h exp=FFFF", HIT_COUNT); end
        cpu(0, 0, 8'h00, 8'h00);
    endtask
`endif

    initial begin
        test_reset();
        test_read_miss();
        test_write_hit();
        test_dirty_miss();
        test_reset_mid();
        test_withdraw();
        test_fast_mem();
        test_write_miss();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back data cache and its controller.
- Sits between the processor datapath (load/store issue from the control unit and ALU address) and the word-wide data memory.
- Serves byte reads and writes from cache lines; stalls the CPU with BUSYWAIT on a miss.
- Sequences line writeback and refill through a busy-wait handshake with memory.

Parameters:
- ADDR_W, 8, CPU byte-address width.
- NUM_LINES, 8, number of cache lines (power of two). Index width IDX_W = log2(NUM_LINES).
- LINE_BYTES, 4, bytes per line. Offset width OFF_W = log2(LINE_BYTES). Tag width TAG_W = ADDR_W-IDX_W-OFF_W.

Ports:
- CLK  in  1  clock; all state changes on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- READ  in  1  CPU load request.
- WRITE  in  1  CPU store request.
- ADDRESS  in  ADDR_W  CPU byte address; split as {tag, index, offset}.
- WRITEDATA  in  8  store data.
- READDATA  out  8  load data.
- BUSYWAIT  out  1  CPU stall.
- MEM_READ  out  1  memory line-read request.
- MEM_WRITE  out  1  memory line-write request.
- MEM_ADDRESS  out  ADDR_W-OFF_W  line address.
- MEM_WRITEDATA  out  8*LINE_BYTES  line being written back.
- MEM_READDATA  in  8*LINE_BYTES  refill line.
- MEM_BUSYWAIT  in  1  memory busy; low marks the cycle the transfer completes.

Behaviour:
- Reset (async assert):
  - All valid and dirty bits cleared; state to IDLE.
  - READDATA=0, BUSYWAIT=0, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0.
  - Tag and data arrays are not cleared.
- hit = valid[index] & (tag_array[index]==tag).
- BUSYWAIT is combinational:
  - High in IDLE when (READ|WRITE) & ~hit.
  - High in every non-IDLE state.
  - Low otherwise.
- Read hit: READDATA = selected byte of the line, combinationally in the same cycle, BUSYWAIT=0. Zero-cycle stall.
- Write hit: byte written and dirty[index] set at the next rising edge, BUSYWAIT=0.
- READ and WRITE both high: treated as a write; READDATA is don't-care.
- FSM states: IDLE, WRITEBACK, REFILL, UPDATE.
  - IDLE -> WRITEBACK on a miss with valid&dirty victim.
  - IDLE -> REFILL on a miss with a clean or invalid victim.
  - WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={victim tag, index}, MEM_WRITEDATA=victim line. On MEM_BUSYWAIT low -> REFILL.
  - REFILL: MEM_READ=1, MEM_ADDRESS={tag, index}. On MEM_BUSYWAIT low -> UPDATE.
  - UPDATE: MEM_READ/MEM_WRITE deasserted. Line <- MEM_READDATA, tag written, valid=1, dirty=0. Next state IDLE.
  - Back in IDLE the request re-evaluates as a hit: a read returns data, a write completes on the following edge.
- MEM_READ and MEM_WRITE are registered, never high together, and drop in the same cycle the FSM leaves their state.
- Miss latency, read: 2 + refill memory cycles, plus writeback cycles if the victim is dirty.
- CPU request withdrawn mid-miss: the in-flight transfer and refill still complete; no partial line is written.
- Address changed mid-miss: undefined. The CPU holds ADDRESS while BUSYWAIT=1.
- Reset mid-transfer: returns to IDLE immediately, memory requests drop, lines are invalidated.
- MEM_BUSYWAIT low on the first cycle of WRITEBACK/REFILL is legal (1-cycle transfer).

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - Adds outputs HIT_COUNT[15:0] and MISS_COUNT[15:0], both saturating at 16'hFFFF and cleared by reset.
  - A hit counts once per IDLE cycle with an accepted hit and BUSYWAIT=0.
  - A miss counts once on each IDLE->WRITEBACK/REFILL transition.
  - The final post-refill hit is not counted.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dcache_pkg:
  - State enum (IDLE=2'd0, WRITEBACK=2'd1, REFILL=2'd2, UPDATE=2'd3).
  - Width constants IDX_W, OFF_W, TAG_W.
  - Address-field extraction functions.
- Sub-module dcache_line_array: tag/valid/dirty/data storage.
  - Combinational read port.
  - Synchronous byte-write and line-fill ports.
  - Async clear of valid/dirty.
- The FSM stays in dcache_controller.

Test Plan:
- Reset, then READ addr 8'h14 (memory line 5 = 32'hDDCCBBAA), memory latency 5:
  - BUSYWAIT=1, MEM_READ=1 with MEM_ADDRESS=6'h05 for 5 cycles, UPDATE.
  - Then READDATA=8'hAA, BUSYWAIT=0.
- WRITE 8'h5A to 8'h15 after the above:
  - BUSYWAIT stays 0, no memory request.
  - Subsequent READ 8'h15 returns 8'h5A.
- READ 8'h34 (same index 5, tag 1) with the line dirty:
  - WRITEBACK with MEM_ADDRESS=6'h05 and MEM_WRITEDATA=32'hDDCC5AAA.
  - Then REFILL at 6'h0D; MEM_WRITE/MEM_READ never overlap.
- RESET_N pulsed low during REFILL:
  - MEM_READ drops asynchronously, BUSYWAIT=0.
  - Next READ 8'h14 misses again.
- Request READ withdrawn after 1 cycle of REFILL: refill completes, line valid; later READ hits with zero stall.
- With DCACHE_STATS_EN: sequence miss, hit, hit, miss gives HIT_COUNT=2, MISS_COUNT=2; counter preloaded near the top saturates at 16'hFFFF.
